// File: rtl/mems_spi_pkg.sv
// Shared constants for the MEMS DAC SPI transmitter and the sequencer that drives it.
// Holds the frame defaults, the state encoding and a counter-width helper.
package mems_spi_pkg;

    localparam int DAC_WORD_BITS  = 24;
    localparam int DAC_HALF_DIV   = 2;
    localparam int DAC_GAP_CYCLES = 2;

    // Encoding is visible to the sequencer, so keep these values stable.
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SETUP    = 3'd1;
    localparam logic [2:0] ST_SHIFT_LO = 3'd2;
    localparam logic [2:0] ST_SHIFT_HI = 3'd3;
    localparam logic [2:0] ST_GAP      = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        SETUP    = ST_SETUP,
        SHIFT_LO = ST_SHIFT_LO,
        SHIFT_HI = ST_SHIFT_HI,
        GAP      = ST_GAP
    } state_t;

    // Down-counter width for a count of n cycles; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mems_dac_spi_tx_if.sv
// Sequencer-side request/status handshake plus the three-wire DAC serial port.
// The sequencer uses master, the transmitter uses slave.
interface mems_dac_spi_tx_if #(
    parameter int WORD_BITS = mems_spi_pkg::DAC_WORD_BITS
);
    logic                 start;
    logic [WORD_BITS-1:0] data;
    logic                 busy;
    logic                 done;
    logic                 sclk;
    logic                 sync_n;
    logic                 mosi;

    modport master (
        output start, data,
        input  busy, done, sclk, sync_n, mosi
    );

    modport slave (
        input  start, data,
        output busy, done, sclk, sync_n, mosi
    );
endinterface

// File: rtl/mems_spi_tick.sv
// Half-period down-counter: load on demand, count to zero and stop there.
// tc is high while the count sits at zero.
module mems_spi_tick #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);
    logic [WIDTH-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign tc = (count == '0);
endmodule

// File: rtl/mems_dac_spi_tx.sv
// Serialises one DAC command word per start pulse: sync_n frame, sclk idling high,
// MSB first, data sampled by the DAC on falling sclk, fixed sync_n-high gap after each word.
module mems_dac_spi_tx
    import mems_spi_pkg::*;
#(
    parameter int WORD_BITS  = DAC_WORD_BITS,
    parameter int HALF_DIV   = DAC_HALF_DIV,
    parameter int GAP_CYCLES = DAC_GAP_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    mems_dac_spi_tx_if.slave bus
);
    localparam int HALF_W = cnt_width(HALF_DIV);
    localparam int GAP_W  = cnt_width(GAP_CYCLES);
    localparam int BIT_W  = $clog2(WORD_BITS + 1);

    localparam logic [HALF_W-1:0] HALF_LOAD = HALF_W'(HALF_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);

    state_t               state;
    state_t               next_state;
    logic [WORD_BITS-1:0] shreg;
    logic [BIT_W-1:0]     bit_cnt;
    logic [GAP_W-1:0]     gap_cnt;
    logic                 half_tc;
    logic                 gap_tc;
    logic                 last_bit;
    logic                 state_change;
    logic [HALF_W-1:0]    half_load_val;

    assign last_bit     = (bit_cnt == BIT_W'(WORD_BITS));
    assign gap_tc       = (gap_cnt == '0);
    assign state_change = (next_state != state);

    mems_spi_tick #(
        .WIDTH (HALF_W)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .load     (state_change),
        .load_val (half_load_val),
        .tc       (half_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        next_state    = state;
        half_load_val = '0;
        unique case (state)
            IDLE:     if (bus.start) next_state = SETUP;
            SETUP:    if (half_tc)   next_state = SHIFT_LO;
            SHIFT_LO: if (half_tc)   next_state = SHIFT_HI;
            SHIFT_HI: if (half_tc)   next_state = last_bit ? GAP : SHIFT_LO;
            GAP:      if (gap_tc)    next_state = IDLE;
            default:                 next_state = IDLE;
        endcase
        if (next_state == SETUP || next_state == SHIFT_LO || next_state == SHIFT_HI) begin
            half_load_val = HALF_LOAD;
        end
    end

    // Outputs are decoded from next_state and registered, so they move with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.sclk   <= 1'b1;
            bus.sync_n <= 1'b1;
            bus.mosi   <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
        end else begin
            bus.busy   <= (next_state != IDLE);
            bus.done   <= (state == GAP) && (next_state == IDLE);
            bus.sclk   <= (next_state != SHIFT_LO);
            bus.sync_n <= (next_state == IDLE) || (next_state == GAP);

            if (state == IDLE && next_state == SETUP) begin
                shreg    <= bus.data;
                bus.mosi <= bus.data[WORD_BITS-1];
                bit_cnt  <= '0;
            end else if (state == SHIFT_LO && next_state == SHIFT_HI) begin
                // The last bit holds through the final high phase.
                if (!last_bit) begin
                    shreg    <= shreg << 1;
                    bus.mosi <= shreg[WORD_BITS-2];
                end
            end else if (next_state == GAP || next_state == IDLE) begin
                bus.mosi <= 1'b0;
            end

            if (next_state == SHIFT_LO && state != SHIFT_LO) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end

            if (state_change) begin
                gap_cnt <= (next_state == GAP) ? GAP_LOAD : '0;
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_mems_dac_spi_tx.sv
// Scoreboard bench for mems_dac_spi_tx: default-timing and fast-timing instances, directed words.
// The monitor rebuilds each frame from the serial pins and compares it at the done pulse.
module tb_mems_dac_spi_tx;
    import mems_spi_pkg::*;

    typedef struct {
        logic [23:0] word;
        int          len;
        int          gap;
    } exp_t;

    logic clk;
    logic rst;
    logic sel;
    int   checks;
    int   failures;
    exp_t sb[$];

    mems_dac_spi_tx_if #(.WORD_BITS(24)) a_if ();
    mems_dac_spi_tx_if #(.WORD_BITS(24)) b_if ();

    mems_dac_spi_tx #(
        .WORD_BITS  (24),
        .HALF_DIV   (2),
        .GAP_CYCLES (2)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    mems_dac_spi_tx #(
        .WORD_BITS  (24),
        .HALF_DIV   (1),
        .GAP_CYCLES (1)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic m_busy, m_done, m_sclk, m_sync_n, m_mosi;
    assign m_busy   = sel ? b_if.busy   : a_if.busy;
    assign m_done   = sel ? b_if.done   : a_if.done;
    assign m_sclk   = sel ? b_if.sclk   : a_if.sclk;
    assign m_sync_n = sel ? b_if.sync_n : a_if.sync_n;
    assign m_mosi   = sel ? b_if.mosi   : a_if.mosi;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: frame capture at the falling clk edge, compare on each done pulse.
    logic [23:0] word;
    int          falls, busy_len, gap_hi, proto_err;
    logic        in_frame, prev_sclk, prev_sync, prev_mosi;
    exp_t        e;

    always @(negedge clk) begin
        if (rst) begin
            in_frame  = 1'b0;
            prev_sclk = 1'b1;
            prev_sync = 1'b1;
            prev_mosi = 1'b0;
        end else begin
            if (m_busy) begin
                if (!in_frame) begin
                    in_frame  = 1'b1;
                    word      = '0;
                    falls     = 0;
                    busy_len  = 0;
                    gap_hi    = 0;
                    proto_err = 0;
                end
                busy_len++;
                if (m_sync_n) gap_hi++;
                if (prev_sclk && !m_sclk) begin
                    word = {word[22:0], m_mosi};
                    falls++;
                    if (m_sync_n) proto_err++;
                end
            end
            if (!m_sclk && (m_mosi !== prev_mosi || m_sync_n !== prev_sync)) proto_err++;
            if (m_done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("word",      32'(word),     32'(e.word));
                    check("falls",     32'(falls),    32'd24);
                    check("busy_len",  32'(busy_len), 32'(e.len));
                    check("gap_hi",    32'(gap_hi),   32'(e.gap));
                    check("proto_err", 32'(proto_err), 32'd0);
                end
            end
            if (!m_busy) in_frame = 1'b0;
            prev_sclk = m_sclk;
            prev_sync = m_sync_n;
            prev_mosi = m_mosi;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [23:0] w, input int len, input int gap);
        exp_t x;
        x.word = w;
        x.len  = len;
        x.gap  = gap;
        sb.push_back(x);
    endtask

    // Start is held for one cycle; data is scrambled afterwards to catch late sampling.
    task automatic drive_start(input logic to_b, input logic [23:0] w);
        if (to_b) begin
            b_if.start = 1'b1;
            b_if.data  = w;
        end else begin
            a_if.start = 1'b1;
            a_if.data  = w;
        end
        step(1);
        a_if.start = 1'b0;
        b_if.start = 1'b0;
        a_if.data  = ~w;
        b_if.data  = ~w;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || m_busy) && n < budget) begin
            step(1);
            n++;
        end
        check({name, "_drained"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_idle(input string name);
        check({name, "_busy"},   32'(a_if.busy),   32'd0);
        check({name, "_done"},   32'(a_if.done),   32'd0);
        check({name, "_sclk"},   32'(a_if.sclk),   32'd1);
        check({name, "_sync_n"}, 32'(a_if.sync_n), 32'd1);
        check({name, "_mosi"},   32'(a_if.mosi),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        checks     = 0;
        failures   = 0;
        sel        = 1'b0;
        rst        = 1'b1;
        a_if.start = 1'b0;
        a_if.data  = '0;
        b_if.start = 1'b0;
        b_if.data  = '0;
        step(3);
        rst = 1'b0;
        step(1);
        @(negedge clk);
        check_idle("reset");
        check("reset_b_sync_n", 32'(b_if.sync_n), 32'd1);
        check("reset_b_sclk",   32'(b_if.sclk),   32'd1);
        step(1);

        // Single default frame.
        push(24'h280001, 100, 2);
        drive_start(1'b0, 24'h280001);
        wait_idle("single", 300);

        // Extra starts at cycles 1, 50 and 99 after the accepted start are ignored.
        push(24'h280001, 100, 2);
        drive_start(1'b0, 24'h280001);
        drive_start(1'b0, 24'hFFFFFF);
        step(48);
        drive_start(1'b0, 24'h000000);
        step(48);
        check("ignore_busy_c99", 32'(a_if.busy), 32'd1);
        drive_start(1'b0, 24'h5A5A5A);
        wait_idle("ignore", 300);

        // Back-to-back: second start lands on the done cycle.
        push(24'h380001, 100, 2);
        drive_start(1'b0, 24'h380001);
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            step(1);
            if (a_if.done) seen = 1'b1;
        end
        check("b2b_done_seen", 32'(seen), 32'd1);
        push(24'h1F8000, 100, 2);
        drive_start(1'b0, 24'h1F8000);
        check("b2b_accepted", 32'(a_if.busy), 32'd1);
        wait_idle("b2b", 300);

        // Reset at cycle 40 of a frame, with a coincident start that must be ignored.
        drive_start(1'b0, 24'hC3C3C3);
        step(39);
        rst        = 1'b1;
        a_if.start = 1'b1;
        a_if.data  = 24'h123456;
        step(1);
        rst        = 1'b0;
        a_if.start = 1'b0;
        @(negedge clk);
        check_idle("abort");
        step(1);
        @(negedge clk);
        check("abort_no_start", 32'(a_if.busy), 32'd0);
        step(120);
        push(24'hA5C3F0, 100, 2);
        drive_start(1'b0, 24'hA5C3F0);
        wait_idle("after_abort", 300);

        // Fastest legal timing.
        sel = 1'b1;
        step(2);
        push(24'hFFFFFF, 50, 1);
        drive_start(1'b1, 24'hFFFFFF);
        wait_idle("fast_ones", 200);
        push(24'h000000, 50, 1);
        drive_start(1'b1, 24'h000000);
        wait_idle("fast_zeros", 200);

        step(5);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
